// File: rtl/serial_rca_pkg.sv
// Shared types and helpers for the bit-serial ripple-carry adder.
package serial_rca_pkg;

    // Controller states: wait for operands, shift/add one bit per clock, hold result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } srca_state_t;

    // Bit counter width; it must be able to hold WIDTH after the final ADD increment.
    function automatic int srca_count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_rca_adder_half_adder_cell.sv
// Gate-level half adder: sum is the XOR, carry is the AND of the two inputs.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    xor u_xor (sum, a, b);
    and u_and (carry, a, b);

endmodule

// File: rtl/serial_rca_adder.sv
// Bit-serial ripple-carry adder. Operands are captured on the start handshake,
// then one bit per clock (LSB first) goes through a full adder built from two
// half-adder cells and an OR. A single carry flop links consecutive bits, and
// the result is held until the consumer takes it.
module serial_rca_adder
    import serial_rca_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int             CW       = srca_count_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    srca_state_t      r_state;
    srca_state_t      w_state_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_a_shifted;
    logic [WIDTH-1:0] w_b_shifted;
    logic [WIDTH-1:0] w_sum_shifted;

    logic             w_ha0_sum;
    logic             w_ha0_carry;
    logic             w_ha1_sum;
    logic             w_ha1_carry;
    logic             w_bit_carry;
    logic             w_last_bit;

    // Full adder for the current LSB: first cell adds the operand bits,
    // second cell folds in the running carry, OR merges the two carries.
    half_adder_cell u_ha0 (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .sum   (w_ha0_sum),
        .carry (w_ha0_carry)
    );

    half_adder_cell u_ha1 (
        .a     (w_ha0_sum),
        .b     (r_carry),
        .sum   (w_ha1_sum),
        .carry (w_ha1_carry)
    );

    assign w_bit_carry = w_ha0_carry | w_ha1_carry;
    assign w_last_bit  = (r_count == LAST_BIT);

    // Right-shift paths: operands fill with zero at the top, the sum register
    // takes the freshly computed bit at the top so it ends up LSB-aligned.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_msb
                assign w_a_shifted[gi]   = 1'b0;
                assign w_b_shifted[gi]   = 1'b0;
                assign w_sum_shifted[gi] = w_ha1_sum;
            end else begin : g_inner
                assign w_a_shifted[gi]   = r_a_sh[gi+1];
                assign w_b_shifted[gi]   = r_b_sh[gi+1];
                assign w_sum_shifted[gi] = r_sum_sh[gi+1];
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, run WIDTH bit steps, wait for the consumer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start_valid) w_state_next = ADD;
            ADD:     if (w_last_bit)  w_state_next = DONE;
            DONE:    if (done_ready)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: load on accept, shift and add one bit per ADD cycle, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_a_sh   <= op_a;
                        r_b_sh   <= op_b;
                        r_carry  <= cin;
                        r_sum_sh <= '0;
                        r_count  <= '0;
                    end
                end
                ADD: begin
                    r_a_sh   <= w_a_shifted;
                    r_b_sh   <= w_b_shifted;
                    r_sum_sh <= w_sum_shifted;
                    r_carry  <= w_bit_carry;
                    r_count  <= r_count + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result comes straight from registers, so it stays put while the consumer stalls.
    assign sum         = r_sum_sh;
    assign cout        = r_carry;
    assign start_ready = (r_state == IDLE);
    assign done_valid  = (r_state == DONE);
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_serial_rca_adder.sv
// Self-checking bench for serial_rca_adder: directed cases, backpressure,
// mid-operation reset, back-to-back throughput and random operands at
// WIDTH=8, plus free-running random checks on WIDTH=1 and WIDTH=13 instances.
module tb_serial_rca_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         rst_x_n = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         done_valid;
    logic         done_ready = 1'b0;
    logic         busy;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [1:0]   x_done = 2'b00;

    always #5 clk = ~clk;

    serial_rca_adder #(.WIDTH(W)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
        .sum         (sum),
        .cout        (cout),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // m_age: -1 when idle, otherwise clocks since the accepting edge (W = result ready).
    int           m_age = -1;
    logic [W:0]   m_last = '0;
    logic [W:0]   exp_q[$];
    int           cycle = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_age  = -1;
                m_last = '0;
                exp_q.delete();
            end else begin
                cycle++;
                if (m_age < 0) begin
                    if (start_valid) begin
                        m_age = 0;
                        exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + (W+1)'(cin));
                    end
                end else if (m_age < W) begin
                    m_age++;
                end else if (done_ready) begin
                    m_age  = -1;
                    m_last = exp_q.pop_front();
                end
            end
        end
    end

    // Compare process: handshake flags every cycle, result whenever it is defined.
    initial begin
        forever begin
            @(negedge clk);
            check("start_ready", start_ready, (m_age < 0));
            check("busy", busy, (m_age >= 0));
            check("done_valid", done_valid, (m_age == W));
            if (m_age == W && exp_q.size() > 0)
                check("model_result", {cout, sum}, exp_q[0]);
            else if (m_age < 0)
                check("idle_hold", {cout, sum}, m_last);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(output int n);
        n = 0;
        while (!done_valid && n < 100) begin
            tick();
            n++;
        end
        check("done_reached", done_valid, 1'b1);
    endtask

    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input bit lit, input logic [W:0] lit_exp, input int stall);
        int n;
        logic [W:0] exp;
        op_a = a;
        op_b = b;
        cin = c;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        check("accept_busy", busy, 1'b1);
        wait_done(n);
        check("latency", n, W);
        exp = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        if (lit) check("literal_result", {cout, sum}, lit_exp);
        else     check("random_result", {cout, sum}, exp);
        repeat (stall) tick();
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check("back_to_idle", start_ready, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int t_acc[3];
        logic [W-1:0] ta[3];
        logic [W-1:0] tb_[3];
        logic         tc[3];

        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_start_ready", start_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done_valid", done_valid, 1'b0);
        check("rst_sum", {cout, sum}, 9'h000);
        rst_n = 1'b1;
        tick();

        // directed arithmetic cases
        run_add(8'h00, 8'h00, 1'b0, 1'b1, 9'h000, 0);
        run_add(8'hFF, 8'h01, 1'b0, 1'b1, 9'h100, 0);
        run_add(8'hA5, 8'h5A, 1'b1, 1'b1, 9'h100, 1);
        run_add(8'h7F, 8'h01, 1'b0, 1'b1, 9'h080, 0);

        // backpressure: result stays, no accept while DONE
        op_a = 8'h3C; op_b = 8'hC3; cin = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        wait_done(n);
        op_a = 8'h11; op_b = 8'h22; cin = 1'b1;
        start_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_result", {cout, sum}, 9'h0FF);
            check("bp_start_ready", start_ready, 1'b0);
            check("bp_done_valid", done_valid, 1'b1);
        end
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check("bp_release_idle", start_ready, 1'b1);
        check("bp_release_busy", busy, 1'b0);
        tick();
        check("bp_next_accept", busy, 1'b1);
        start_valid = 1'b0;
        wait_done(n);
        check("bp_next_result", {cout, sum}, 9'h034);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;

        // reset in the middle of ADD
        op_a = 8'h12; op_b = 8'h34; cin = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("abort_done_valid", done_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_result", {cout, sum}, 9'h000);
        check("abort_start_ready", start_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        run_add(8'h40, 8'h41, 1'b0, 1'b1, 9'h081, 0);

        // back-to-back with both handshakes held high
        ta[0] = 8'h01; tb_[0] = 8'h02; tc[0] = 1'b0;
        ta[1] = 8'h80; tb_[1] = 8'h80; tc[1] = 1'b1;
        ta[2] = 8'hFF; tb_[2] = 8'hFF; tc[2] = 1'b1;
        start_valid = 1'b1;
        done_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op_a = ta[i]; op_b = tb_[i]; cin = tc[i];
            n = 0;
            if (i > 0) begin
                while (busy && n < 50) begin tick(); n++; end
            end
            while (!busy && n < 50) begin tick(); n++; end
            check("b2b_accept_seen", busy, 1'b1);
            t_acc[i] = cycle;
        end
        start_valid = 1'b0;
        check("b2b_gap_1", t_acc[1] - t_acc[0], W + 2);
        check("b2b_gap_2", t_acc[2] - t_acc[1], W + 2);
        n = 0;
        while (!done_valid && n < 50) begin tick(); n++; end
        check("b2b_last_result", {cout, sum}, 9'h1FF);
        tick();
        done_ready = 1'b0;
        check("b2b_idle", start_ready, 1'b1);

        // random operands with random consumer stalls
        for (int i = 0; i < 500; i++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), 1'b0, '0, $urandom_range(0, 2));
        end

        n = 0;
        while (x_done != 2'b11 && n < 20000) begin tick(); n++; end
        check("other_widths_finished", x_done, 2'b11);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // ---------------- WIDTH=1 and WIDTH=13 instances ----------------
    initial begin
        #1 rst_x_n = 1'b0;
        #22 rst_x_n = 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_xw
            localparam int XW = (gi == 0) ? 1 : 13;

            logic          x_sv = 1'b0;
            logic          x_sr;
            logic [XW-1:0] x_a = '0;
            logic [XW-1:0] x_b = '0;
            logic          x_cin = 1'b0;
            logic [XW-1:0] x_sum;
            logic          x_cout;
            logic          x_dv;
            logic          x_dr = 1'b0;
            logic          x_busy;

            serial_rca_adder #(.WIDTH(XW)) u_dut_x (
                .clk         (clk),
                .rst_n       (rst_x_n),
                .start_valid (x_sv),
                .start_ready (x_sr),
                .op_a        (x_a),
                .op_b        (x_b),
                .cin         (x_cin),
                .sum         (x_sum),
                .cout        (x_cout),
                .done_valid  (x_dv),
                .done_ready  (x_dr),
                .busy        (x_busy)
            );

            initial begin
                int n;
                logic [XW:0] exp;
                #30;
                tick();
                for (int k = 0; k < 150; k++) begin
                    check("x_idle_ready", x_sr, 1'b1);
                    x_a = XW'($urandom);
                    x_b = XW'($urandom);
                    x_cin = 1'($urandom);
                    exp = {1'b0, x_a} + {1'b0, x_b} + (XW+1)'(x_cin);
                    x_sv = 1'b1;
                    tick();
                    x_sv = 1'b0;
                    n = 0;
                    while (!x_dv && n < 50) begin tick(); n++; end
                    check("x_latency", n, XW);
                    check("x_result", {x_cout, x_sum}, exp);
                    x_dr = 1'b1;
                    tick();
                    x_dr = 1'b0;
                end
                x_done[gi] = 1'b1;
            end
        end
    endgenerate

endmodule
